// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package spi_pkg;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_XFER     = 2'd2,
    ST_CS_HOLD  = 2'd3
  } spi_state_e;

  // SPI modes encoded as {cpol, cpha}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Mirror the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(w)) r[i] = v[5'(int'(w) - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter, SCLK toggle and leading/trailing edge strobes.
// Latency: tick asserts on the (clk_div+1)-th enabled cycle; SCLK changes on the edge after a strobe.
// Backpressure: none; en/clr/toggle_en/load come straight from the controlling FSM.
// Ports: clk, reset (sync, active-low); clk_div = half-period minus one; en counts, clr zeroes
//        the counter; toggle_en lets SCLK toggle on tick; load forces SCLK to load_val;
//        idle_lvl is CPOL. Outputs: tick, lead_edge, trail_edge, sclk.
module spi_sclk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             en,
  input  logic             clr,
  input  logic             toggle_en,
  input  logic             load,
  input  logic             load_val,
  input  logic             idle_lvl,
  output logic             tick,
  output logic             lead_edge,
  output logic             trail_edge,
  output logic             sclk
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  assign tick = en && (cnt_q == clk_div);

  // A toggle away from the idle level is a leading edge, back towards it a trailing edge.
  assign lead_edge  = tick && toggle_en && (sclk_q == idle_lvl);
  assign trail_edge = tick && toggle_en && (sclk_q != idle_lvl);
  assign sclk       = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr || tick) cnt_d = '0;
    else if (en)     cnt_d = cnt_q + 1'b1;
    if (load)                   sclk_d = load_val;
    else if (tick && toggle_en) sclk_d = ~sclk_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable width, divider, one-hot CS, bit order and CS-keep bursts.
// Latency: accept to done (2*DATA_W+2)*H+1 cycles, H = clk_div+1; minus H for each skipped CS phase.
// Backpressure: start is taken only while ready=1; start while busy is ignored.
// Ports: clk, reset (sync, active-low); start/ready/busy/done handshake; cpol, cpha, lsb_first,
//        cs_sel, cs_keep, clk_div, tx_data configure a word; rx_data is the last received word;
//        SCLK, MOSI, MISO, cs_n form the serial bus.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CSW-1:0]    cs_sel,
  input  logic              cs_keep,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              ready,
  output logic              done,
  output logic              busy,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int BCW = $clog2(DATA_W);

  spi_state_e          state_q, state_d;
  logic                cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, keep_q, keep_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d, cs_dec;
  logic                held_q, held_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d, tx_word;
  logic                mosi_q, mosi_d, ready_q, ready_d, done_q, done_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic                accept, load, finish, last_trail, sample;
  logic                tick, lead_edge, trail_edge;

  spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk (
    .clk       (clk),
    .reset     (reset),
    .clk_div   (div_q),
    .en        (state_q != ST_IDLE),
    .clr       (state_q == ST_IDLE),
    .toggle_en (state_q == ST_XFER),
    .load      (load),
    .load_val  (cpol),
    .idle_lvl  (cpol_q),
    .tick      (tick),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge),
    .sclk      (SCLK)
  );

  assign accept     = start && ready_q;
  // The shifter always works MSB-first; LSB-first words are mirrored on the way in and out.
  assign tx_word    = lsb_first ? DATA_W'(bit_rev(32'(tx_data), DATA_W)) : tx_data;
  assign last_trail = trail_edge && (bcnt_q == BCW'(DATA_W - 1));
  assign sample     = cpha_q ? trail_edge : lead_edge;

  // An out-of-range cs_sel leaves every line deasserted.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(cs_sel) == i) cs_dec[i] = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    keep_d    = keep_q;
    div_d     = div_q;
    cs_n_d    = cs_n_q;
    held_d    = held_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    mosi_d    = mosi_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    bcnt_d    = bcnt_q;
    load      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          keep_d  = cs_keep;
          div_d   = clk_div;
          ready_d = 1'b0;
          bcnt_d  = '0;
          load    = 1'b1;
          // With cpha=0 the first bit must already be on MOSI before the first leading edge.
          if (cpha) begin
            tx_sh_d = tx_word;
          end else begin
            tx_sh_d = tx_word << 1;
            mosi_d  = tx_word[DATA_W-1];
          end
          // A held burst line skips setup and ignores the new cs_sel.
          if (held_q) begin
            state_d = ST_XFER;
          end else begin
            state_d = ST_CS_SETUP;
            cs_n_d  = cs_dec;
          end
        end
      end
      ST_CS_SETUP: begin
        if (tick) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (sample) rx_sh_d = {rx_sh_q[DATA_W-2:0], MISO};
        if (cpha_q ? lead_edge : (trail_edge && !last_trail)) begin
          mosi_d  = tx_sh_q[DATA_W-1];
          tx_sh_d = tx_sh_q << 1;
        end
        if (trail_edge) bcnt_d = bcnt_q + 1'b1;
        if (last_trail) begin
          if (keep_q) begin
            state_d = ST_IDLE;
            held_d  = 1'b1;
            finish  = 1'b1;
          end else begin
            state_d = ST_CS_HOLD;
            held_d  = 1'b0;
          end
        end
      end
      ST_CS_HOLD: begin
        if (tick) begin
          state_d = ST_IDLE;
          cs_n_d  = '1;
          finish  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // rx_sh_d is used so a sample taken on the completing edge is included.
    if (finish) begin
      done_d    = 1'b1;
      ready_d   = 1'b1;
      rx_data_d = lsb_q ? DATA_W'(bit_rev(32'(rx_sh_d), DATA_W)) : rx_sh_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      keep_q    <= 1'b0;
      div_q     <= '0;
      cs_n_q    <= '1;
      held_q    <= 1'b0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      keep_q    <= keep_d;
      div_q     <= div_d;
      cs_n_q    <= cs_n_d;
      held_q    <= held_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      mosi_q    <= mosi_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign rx_data = rx_data_q;
  assign ready   = ready_q;
  assign busy    = ~ready_q;
  assign done    = done_q;
  assign MOSI    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: directed scenarios plus randomized words against a word-level model.
// Latency: measured as negedges from the accepting edge to the first negedge with done=1.
// Backpressure: start is driven only when ready is seen, except the start-held-high scenario.
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int DW   = 8;
  localparam int NCS  = 6;
  localparam int DIVW = 8;
  localparam int CSW  = $clog2(NCS);

  logic            clk = 1'b0;
  logic            reset, start, cpol, cpha, lsb_first, cs_keep;
  logic [CSW-1:0]  cs_sel;
  logic [DIVW-1:0] clk_div;
  logic [DW-1:0]   tx_data, rx_data;
  logic            ready, done, busy, sclk, mosi, miso;
  logic [NCS-1:0]  cs_n;
  logic            loop_en, slave_bit;

  assign miso = loop_en ? mosi : slave_bit;
  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(DIVW)) dut (
    .clk(clk), .reset(reset), .start(start), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .cs_sel(cs_sel), .cs_keep(cs_keep), .clk_div(clk_div),
    .tx_data(tx_data), .rx_data(rx_data), .ready(ready), .done(done), .busy(busy),
    .SCLK(sclk), .MOSI(mosi), .MISO(miso), .cs_n(cs_n)
  );

  int checks = 0;
  int errors = 0;

  // Word-level model state and per-word expectations.
  logic           model_held;
  logic [NCS-1:0] model_cs, exp_cs;
  logic [DW-1:0]  last_rx, exp_rx, exp_tx;
  logic           exp_keep, w_cpol, w_cpha, w_lsb, first_bit;
  int             exp_lat, w_h;
  logic           slave_bits[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word on the inputs and derive what the bus must do for it.
  task automatic drive(input logic [DW-1:0] tx, input logic cp, input logic ch, input logic lf,
                       input int sel, input logic keep, input int div, input logic lp,
                       input logic [DW-1:0] sw);
    tx_data = tx; cpol = cp; cpha = ch; lsb_first = lf;
    cs_sel = CSW'(sel); cs_keep = keep; clk_div = DIVW'(div); loop_en = lp;
    w_cpol = cp; w_cpha = ch; w_lsb = lf; w_h = div + 1; exp_keep = keep; exp_tx = tx;
    exp_rx = lp ? tx : sw;
    if (!model_held) begin
      model_cs = '1;
      if (sel < NCS) model_cs[sel] = 1'b0;
    end
    exp_cs  = model_cs;
    exp_lat = (2 * DW + (model_held ? 0 : 1) + (keep ? 0 : 1)) * w_h + 1;
    model_held = keep;
    slave_bits.delete();
    for (int k = 0; k < DW; k++) slave_bits.push_back(lf ? sw[k] : sw[DW-1-k]);
    if (!ch) slave_bit = slave_bits.pop_front();
  endtask

  // Called at a negedge; returns just after the accepting posedge with start still high.
  task automatic launch(input logic [DW-1:0] tx, input logic cp, input logic ch, input logic lf,
                        input int sel, input logic keep, input int div, input logic lp,
                        input logic [DW-1:0] sw);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(ready), 64'(1));
    drive(tx, cp, ch, lf, sel, keep, div, lp, sw);
    start = 1'b1;
    @(posedge clk);
  endtask

  // Watches one word from accept to done; returns at the negedge where done is high.
  task automatic finish_word(input logic hold_start, input string tag);
    int n, leads, trails, last_lead, capn;
    logic prev, period_ok, cs_ok, got_done;
    logic [DW-1:0] cap;
    leads = 0; trails = 0; last_lead = -1; capn = 0;
    period_ok = 1'b1; cs_ok = 1'b1; got_done = 1'b0; cap = '0;
    @(negedge clk);
    n = 1;
    if (!hold_start) start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    chk({tag, "_done_low"}, 64'(done), 64'(0));
    chk({tag, "_rx_hold"}, 64'(rx_data), 64'(last_rx));
    chk({tag, "_sclk_pre"}, 64'(sclk), 64'(w_cpol));
    prev = sclk;
    while (!got_done && n < 3000) begin
      if (sclk !== prev) begin
        if (prev === w_cpol) begin
          if (last_lead >= 0 && (n - last_lead) != 2 * w_h) period_ok = 1'b0;
          last_lead = n;
          leads++;
        end else begin
          trails++;
        end
        // Sampling edge: leading for cpha=0, trailing for cpha=1; the slave moves on the other.
        if ((prev === w_cpol) != w_cpha) begin
          if (capn < DW) begin
            if (capn == 0) first_bit = mosi;
            if (w_lsb) cap[capn] = mosi;
            else       cap[DW-1-capn] = mosi;
            capn++;
          end
        end else if (slave_bits.size() > 0) begin
          slave_bit = slave_bits.pop_front();
        end
        prev = sclk;
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
      end else begin
        if (cs_n !== exp_cs) cs_ok = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    chk({tag, "_done_seen"}, 64'(got_done), 64'(1));
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_rx_data"}, 64'(rx_data), 64'(exp_rx));
    chk({tag, "_mosi_word"}, 64'(cap), 64'(exp_tx));
    chk({tag, "_lead_edges"}, 64'(leads), 64'(DW));
    chk({tag, "_trail_edges"}, 64'(trails), 64'(DW));
    chk({tag, "_sclk_period"}, 64'(period_ok), 64'(1));
    chk({tag, "_cs_during"}, 64'(cs_ok), 64'(1));
    chk({tag, "_sclk_post"}, 64'(sclk), 64'(w_cpol));
    chk({tag, "_ready"}, 64'(ready), 64'(1));
    chk({tag, "_cs_after"}, 64'(cs_n), 64'(exp_keep ? exp_cs : {NCS{1'b1}}));
    last_rx = exp_rx;
  endtask

  initial begin
    int n_done;
    logic [1:0] md;
    logic rcp, rch, rkp;
    reset = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    cs_sel = '0; cs_keep = 1'b0; clk_div = '0; tx_data = '0;
    loop_en = 1'b1; slave_bit = 1'b0; first_bit = 1'b0;
    model_held = 1'b0; model_cs = '1; last_rx = '0;
    w_cpol = 1'b0; w_cpha = 1'b0; w_lsb = 1'b0; w_h = 1;
    repeat (3) @(negedge clk);
    chk("rst_sclk", 64'(sclk), 64'(0));
    chk("rst_mosi", 64'(mosi), 64'(0));
    chk("rst_cs_n", 64'(cs_n), 64'({NCS{1'b1}}));
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rx", 64'(rx_data), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Mode 0 loopback, CS line 2.
    launch(8'hA5, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1, 1'b1, 8'h00);
    finish_word(1'b0, "t1");

    // Remaining modes in loopback.
    for (int m = 1; m < 4; m++) begin
      md = 2'(m);
      launch(8'h3C, md[1], md[0], 1'b0, 1, 1'b0, 1, 1'b1, 8'h00);
      finish_word(1'b0, "t2");
    end

    // LSB-first against a slave sending 0x80.
    launch(8'h01, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1, 1'b0, 8'h80);
    finish_word(1'b0, "t3");
    chk("t3_first_mosi", 64'(first_bit), 64'(1));

    // Three-word burst; cs_sel of the later words must be ignored.
    launch(8'h5E, SPI_MODE0[1], SPI_MODE0[0], 1'b0, 1, 1'b1, 1, 1'b1, 8'h00);
    finish_word(1'b0, "t4a");
    launch(8'hC3, SPI_MODE0[1], SPI_MODE0[0], 1'b0, 4, 1'b1, 1, 1'b1, 8'h00);
    finish_word(1'b0, "t4b");
    launch(8'h96, SPI_MODE0[1], SPI_MODE0[0], 1'b0, 0, 1'b0, 1, 1'b1, 8'h00);
    finish_word(1'b0, "t4c");

    // Reset in the middle of the shift phase.
    launch(8'h5A, 1'b0, 1'b1, 1'b0, 3, 1'b0, 2, 1'b1, 8'h00);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_cs_n", 64'(cs_n), 64'({NCS{1'b1}}));
    chk("t5_sclk", 64'(sclk), 64'(0));
    chk("t5_ready", 64'(ready), 64'(1));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_done", 64'(done), 64'(0));
    reset = 1'b1;
    model_held = 1'b0;
    last_rx = '0;
    n_done = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    chk("t5_no_done", 64'(n_done), 64'(0));
    launch(8'hE7, SPI_MODE3[1], SPI_MODE3[0], 1'b0, 5, 1'b0, 0, 1'b1, 8'h00);
    finish_word(1'b0, "t5_after");

    // start held high throughout, with no CS line selected.
    launch(8'h6B, 1'b0, 1'b0, 1'b0, NCS, 1'b0, 0, 1'b1, 8'h00);
    finish_word(1'b1, "t6a");
    drive(8'h94, 1'b1, 1'b0, 1'b0, NCS, 1'b0, 0, 1'b1, 8'h00);
    @(posedge clk);
    finish_word(1'b0, "t6b");

    // Randomized words; cpol/cpha stay fixed while a burst holds CS.
    for (int w = 0; w < 16; w++) begin
      if (model_held) begin
        rcp = w_cpol;
        rch = w_cpha;
      end else begin
        rcp = 1'($urandom_range(0, 1));
        rch = 1'($urandom_range(0, 1));
      end
      rkp = (w == 15) ? 1'b0 : 1'($urandom_range(0, 1));
      launch(DW'($urandom), rcp, rch, 1'($urandom_range(0, 1)), int'($urandom_range(0, NCS)),
             rkp, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), DW'($urandom));
      finish_word(1'b0, "rnd");
    end

    @(negedge clk);
    chk("end_done_pulse", 64'(done), 64'(0));
    chk("end_cs_n", 64'(cs_n), 64'({NCS{1'b1}}));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
